// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: sequential fetch over a req/gnt + in-order rvalid
// memory port, DEPTH-entry instruction buffer toward decode, redirect flush/restart.

module inst_prefetch_queue_chk #(
    parameter int unsigned CW = 3
) (
    input logic          clk,
    input logic          rst,
    input logic          push,
    input logic [CW-1:0] count,
    input logic [CW-1:0] depth
);
    // Flags a buffer write while every entry is occupied
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(push && (count == depth)))
            else $error("inst_prefetch_queue: push into a full buffer");
        end
    end
endmodule

module inst_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req,
    output logic [31:0]                imem_addr,
    input  logic                       imem_gnt,
    input  logic                       imem_rvalid,
    input  logic [31:0]                imem_rdata,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic                       dec_valid,
    output logic [31:0]                dec_instr,
    output logic [31:0]                dec_pc,
    input  logic                       dec_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam logic [CW:0]   DEPTH_WIDE = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] DEPTH_CNT  = CW'(DEPTH);

    logic [31:0]   fetch_pc_r;
    logic [31:0]   resp_pc_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] inflight_r;
    logic [CW-1:0] discard_r;
    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;
    logic [31:0]   instr_mem_r [DEPTH];
    logic [31:0]   pc_mem_r    [DEPTH];

    logic          req_s;
    logic          fire_s;
    logic          push_s;
    logic          pop_s;
    logic [CW:0]   budget_s;
    logic [CW-1:0] inflight_nxt_s;

    // Issue gating, buffer handshakes and the post-response in-flight count
    always_comb begin
        budget_s = {1'b0, count_r} + {1'b0, inflight_r};
        req_s    = !rst && !redirect && (budget_s < DEPTH_WIDE);
        fire_s   = req_s && imem_gnt;
        pop_s    = (count_r != {CW{1'b0}}) && dec_ready;
        // Responses landing while older discards are pending, or during a redirect, never enter the buffer
        push_s   = !rst && !redirect && imem_rvalid && (discard_r == {CW{1'b0}});
        inflight_nxt_s = inflight_r + CW'(fire_s) - CW'(imem_rvalid);
    end

    // Control state: fetch/response PCs, counters and buffer pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r <= RESET_PC;
            resp_pc_r  <= RESET_PC;
            count_r    <= {CW{1'b0}};
            inflight_r <= {CW{1'b0}};
            discard_r  <= {CW{1'b0}};
            head_r     <= {AW{1'b0}};
            tail_r     <= {AW{1'b0}};
        end else if (redirect) begin
            fetch_pc_r <= redirect_pc;
            resp_pc_r  <= redirect_pc;
            count_r    <= {CW{1'b0}};
            inflight_r <= inflight_nxt_s;
            discard_r  <= inflight_nxt_s;
            head_r     <= {AW{1'b0}};
            tail_r     <= {AW{1'b0}};
        end else begin
            if (fire_s) begin
                fetch_pc_r <= fetch_pc_r + 32'd4;
            end
            inflight_r <= inflight_nxt_s;
            if (imem_rvalid && (discard_r != {CW{1'b0}})) begin
                discard_r <= discard_r - CW'(1);
            end
            if (push_s) begin
                resp_pc_r <= resp_pc_r + 32'd4;
                tail_r    <= tail_r + AW'(1);
            end
            if (pop_s) begin
                head_r <= head_r + AW'(1);
            end
            count_r <= count_r + CW'(push_s) - CW'(pop_s);
        end
    end

    // Buffer storage; contents are meaningless until the matching count says otherwise
    always_ff @(posedge clk) begin
        if (push_s) begin
            instr_mem_r[tail_r] <= imem_rdata;
            pc_mem_r[tail_r]    <= resp_pc_r;
        end
    end

    assign imem_req  = req_s;
    assign imem_addr = fetch_pc_r;
    assign dec_valid = (count_r != {CW{1'b0}});
    assign dec_instr = instr_mem_r[head_r];
    assign dec_pc    = pc_mem_r[head_r];
    assign occupancy = count_r;

    inst_prefetch_queue_chk #(.CW(CW)) u_chk (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s && !pop_s),
        .count (count_r),
        .depth (DEPTH_CNT)
    );
endmodule
